// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the shared memory bus: instruction fetch (read-only) and data access.
// Each granted access holds memEn for WAIT_CYCLES cycles, then pulses the requester's ack.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              fetchReq,
    input  logic [ADDR_W-1:0] fetchAddr,
    output logic              fetchAck,
    output logic [DATA_W-1:0] fetchData,
    input  logic              dataReq,
    input  logic              dataRW,
    input  logic [ADDR_W-1:0] dataAddr,
    input  logic [DATA_W-1:0] dataWdata,
    output logic              dataAck,
    output logic [DATA_W-1:0] dataRdata,
    output logic              memEn,
    output logic              memRW,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rw_q, mem_rw_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              grant_data;

    // On a tie the requester not served last wins; lastGrant also names the active requester.
    assign grant_data = dataReq && (!fetchReq || (last_grant_q == GRANT_FETCH));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_rw_d     = mem_rw_q;
        mem_wdata_d  = mem_wdata_q;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;
        case (state_q)
            IDLE: begin
                if (fetchReq || dataReq) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    if (grant_data) begin
                        last_grant_d = GRANT_DATA;
                        mem_addr_d   = dataAddr;
                        mem_rw_d     = dataRW;
                        mem_wdata_d  = dataWdata;
                    end else begin
                        last_grant_d = GRANT_FETCH;
                        mem_addr_d   = fetchAddr;
                        mem_rw_d     = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (mem_rw_q) begin
                        if (last_grant_q == GRANT_DATA) begin
                            data_rdata_d = memRdata;
                        end else begin
                            fetch_data_d = memRdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_FETCH;
            cnt_q        <= 4'd0;
            mem_addr_q   <= '0;
            mem_rw_q     <= 1'b0;
            mem_wdata_q  <= '0;
            fetch_data_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_rw_q     <= mem_rw_d;
            mem_wdata_q  <= mem_wdata_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign memEn     = (state_q == ACCESS);
    assign busy      = (state_q != IDLE);
    assign fetchAck  = (state_q == DONE) && (last_grant_q == GRANT_FETCH);
    assign dataAck   = (state_q == DONE) && (last_grant_q == GRANT_DATA);
    assign memAddr   = mem_addr_q;
    assign memRW     = mem_rw_q;
    assign memWdata  = mem_wdata_q;
    assign fetchData = fetch_data_q;
    assign dataRdata = data_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios plus random traffic checked against
// an edge-count reference model; two extra instances cover WAIT_CYCLES of 1 and 5.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned W  = 2;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          fetchReq = 1'b0;
    logic [AW-1:0] fetchAddr = '0;
    logic          fetchAck;
    logic [DW-1:0] fetchData;
    logic          dataReq = 1'b0;
    logic          dataRW = 1'b0;
    logic [AW-1:0] dataAddr = '0;
    logic [DW-1:0] dataWdata = '0;
    logic          dataAck;
    logic [DW-1:0] dataRdata;
    logic          memEn;
    logic          memRW;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] memRdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .resetN(resetN),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchAck(fetchAck), .fetchData(fetchData),
        .dataReq(dataReq), .dataRW(dataRW), .dataAddr(dataAddr), .dataWdata(dataWdata),
        .dataAck(dataAck), .dataRdata(dataRdata),
        .memEn(memEn), .memRW(memRW), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .busy(busy)
    );

    function automatic logic [31:0] rd_func(input logic [15:0] a);
        if (a == 16'h0010) return 32'hE3A01005;
        return {~a, a} ^ 32'h1234_5678;
    endfunction

    // Memory returns valid data only in the last strobe cycle, so early/late sampling shows up.
    int en_run;
    always @(posedge clk or negedge resetN) begin
        if (!resetN) en_run <= 0;
        else         en_run <= memEn ? en_run + 1 : 0;
    end
    assign memRdata = (memEn && en_run == int'(W) - 1) ? rd_func(memAddr) : 32'hBAD0_BAD0;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    endtask

    // Reference model: one access at a time, granted at edge g, strobe for edges g..g+W-1,
    // ack after edge g+W, next grant no earlier than edge g+W+2.
    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        int          ack_edge;
    } ack_t;

    ack_t        ack_q[$];
    int          g_edge = -100;
    int          free_at = 0;
    bit          act_data = 1'b0;
    bit          last_data = 1'b0;
    bit          pend_rw = 1'b0;
    logic [31:0] pend_rdata = '0;
    logic [15:0] x_maddr = '0;
    logic        x_mrw = 1'b0;
    logic [31:0] x_mwdata = '0;
    logic [31:0] x_fdata = '0;
    logic [31:0] x_drdata = '0;

    task automatic model_reset();
        g_edge    = -100;
        free_at   = 0;
        last_data = 1'b0;
        x_maddr   = '0;
        x_mrw     = 1'b0;
        x_mwdata  = '0;
        x_fdata   = '0;
        x_drdata  = '0;
        ack_q.delete();
    endtask

    always @(negedge resetN) model_reset();

    always @(posedge clk) begin
        cyc++;
        if (!resetN) begin
            model_reset();
        end else begin
            if (cyc == g_edge + int'(W) && pend_rw) begin
                if (act_data) x_drdata = pend_rdata;
                else          x_fdata  = pend_rdata;
            end
            if (cyc >= free_at && (fetchReq || dataReq)) begin
                act_data  = dataReq && (!fetchReq || !last_data);
                last_data = act_data;
                g_edge    = cyc;
                free_at   = cyc + int'(W) + 2;
                if (act_data) begin
                    x_maddr  = dataAddr;
                    x_mrw    = dataRW;
                    x_mwdata = dataWdata;
                end else begin
                    x_maddr = fetchAddr;
                    x_mrw   = 1'b1;
                end
                pend_rw    = x_mrw;
                pend_rdata = rd_func(x_maddr);
                ack_q.push_back('{is_data: act_data,
                                  rdata: x_mrw ? pend_rdata : (act_data ? x_drdata : x_fdata),
                                  ack_edge: cyc + int'(W)});
            end
        end
    end

    // Monitor: compares every output each cycle and pops the scoreboard on each ack.
    logic m_en, m_busy, m_fack, m_dack;
    ack_t p;
    always @(negedge clk) begin
        m_en   = resetN && cyc >= g_edge && cyc <= g_edge + int'(W) - 1;
        m_busy = resetN && cyc >= g_edge && cyc <= g_edge + int'(W);
        m_fack = resetN && cyc == g_edge + int'(W) && !act_data;
        m_dack = resetN && cyc == g_edge + int'(W) && act_data;
        chk("memEn", 32'(memEn), 32'(m_en));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("fetchAck", 32'(fetchAck), 32'(m_fack));
        chk("dataAck", 32'(dataAck), 32'(m_dack));
        chk("ack_overlap", 32'(fetchAck & dataAck), 32'd0);
        chk("memAddr", 32'(memAddr), 32'(x_maddr));
        chk("memRW", 32'(memRW), 32'(x_mrw));
        chk("memWdata", memWdata, x_mwdata);
        chk("fetchData", fetchData, x_fdata);
        chk("dataRdata", dataRdata, x_drdata);
        if (fetchAck || dataAck) begin
            if (ack_q.size() == 0) begin
                n_total++;
                $display("FAIL ack_spurious: got ack with empty scoreboard (edge %0d)", cyc);
            end else begin
                p = ack_q.pop_front();
                chk("ack_who", 32'(dataAck), 32'(p.is_data));
                chk("ack_edge", 32'(cyc), 32'(p.ack_edge));
                chk("ack_data", p.is_data ? dataRdata : fetchData, p.rdata);
            end
        end
    end

    // Auxiliary instances for other WAIT_CYCLES values.
    logic          aux_req [2];
    logic [AW-1:0] aux_addr = '0;
    logic [AW-1:0] aux_zero_a = '0;
    logic [DW-1:0] aux_zero_d = '0;
    logic          aux_zero = 1'b0;
    logic          aux_fack [2];
    logic [DW-1:0] aux_fdata [2];
    logic          aux_dack [2];
    logic [DW-1:0] aux_drdata [2];
    logic          aux_en [2];
    logic          aux_mrw [2];
    logic [AW-1:0] aux_maddr [2];
    logic [DW-1:0] aux_mwdata [2];
    logic [DW-1:0] aux_rdata [2];
    logic          aux_busy [2];

    initial begin
        aux_req[0] = 1'b0;
        aux_req[1] = 1'b0;
    end

    assign aux_rdata[0] = aux_en[0] ? rd_func(aux_maddr[0]) : '0;
    assign aux_rdata[1] = aux_en[1] ? rd_func(aux_maddr[1]) : '0;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .resetN(resetN),
        .fetchReq(aux_req[0]), .fetchAddr(aux_addr), .fetchAck(aux_fack[0]),
        .fetchData(aux_fdata[0]),
        .dataReq(aux_zero), .dataRW(aux_zero), .dataAddr(aux_zero_a), .dataWdata(aux_zero_d),
        .dataAck(aux_dack[0]), .dataRdata(aux_drdata[0]),
        .memEn(aux_en[0]), .memRW(aux_mrw[0]), .memAddr(aux_maddr[0]),
        .memWdata(aux_mwdata[0]), .memRdata(aux_rdata[0]), .busy(aux_busy[0])
    );

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(5)) u_w5 (
        .clk(clk), .resetN(resetN),
        .fetchReq(aux_req[1]), .fetchAddr(aux_addr), .fetchAck(aux_fack[1]),
        .fetchData(aux_fdata[1]),
        .dataReq(aux_zero), .dataRW(aux_zero), .dataAddr(aux_zero_a), .dataWdata(aux_zero_d),
        .dataAck(aux_dack[1]), .dataRdata(aux_drdata[1]),
        .memEn(aux_en[1]), .memRW(aux_mrw[1]), .memAddr(aux_maddr[1]),
        .memWdata(aux_mwdata[1]), .memRdata(aux_rdata[1]), .busy(aux_busy[1])
    );

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Steps until the ack appears; reports steps taken and strobe cycles seen.
    task automatic wait_ack(input bit is_data, input string name, output int lat, output int ens);
        bit hit = 1'b0;
        lat = 0;
        ens = 0;
        while (!hit && lat < 40) begin
            step();
            lat++;
            if (memEn) ens++;
            hit = is_data ? dataAck : fetchAck;
        end
        if (!hit) begin
            n_total++;
            $display("FAIL %s: no ack within 40 cycles", name);
        end
    endtask

    task automatic do_reset();
        step();
        resetN = 1'b0;
        step();
        step();
        resetN = 1'b1;
    endtask

    task automatic aux_run(input int i, input int wexp);
        int lat = 0;
        int ens = 0;
        bit hit = 1'b0;
        step();
        aux_addr   = 16'h0100 + 16'(i);
        aux_req[i] = 1'b1;
        while (!hit && lat < 20) begin
            step();
            lat++;
            if (aux_en[i]) begin
                ens++;
                chk("aux_memRW", 32'(aux_mrw[i]), 32'd1);
                chk("aux_memAddr", 32'(aux_maddr[i]), 32'(aux_addr));
            end
            chk("aux_dataAck", 32'(aux_dack[i]), 32'd0);
            hit = aux_fack[i];
        end
        aux_req[i] = 1'b0;
        chk("aux_ack_latency", 32'(lat), 32'(wexp + 1));
        chk("aux_memEn_width", 32'(ens), 32'(wexp));
        chk("aux_fetchData", aux_fdata[i], rd_func(aux_addr));
        chk("aux_memWdata", aux_mwdata[i], 32'd0);
        chk("aux_dataRdata", aux_drdata[i], 32'd0);
        step();
        chk("aux_idle", 32'(aux_busy[i]), 32'd0);
    endtask

    initial begin
        int lat;
        int ens;
        int order[$];
        int times[$];
        bit re_f;
        bit re_d;
        int guard;

        // Reset values
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_memEn", 32'(memEn), 32'd0);
        resetN = 1'b1;

        // Single fetch
        step();
        fetchAddr = 16'h0010;
        fetchReq  = 1'b1;
        wait_ack(1'b0, "fetch_ack", lat, ens);
        fetchReq = 1'b0;
        chk("fetch_latency", 32'(lat), 32'(W + 1));
        chk("fetch_memEn_width", 32'(ens), 32'(W));
        chk("fetch_word", fetchData, 32'hE3A01005);

        // Store
        step();
        dataRW    = 1'b0;
        dataAddr  = 16'h0200;
        dataWdata = 32'hDEADBEEF;
        dataReq   = 1'b1;
        wait_ack(1'b1, "store_ack", lat, ens);
        dataReq = 1'b0;
        chk("store_memEn_width", 32'(ens), 32'(W));
        chk("store_rdata_kept", dataRdata, 32'd0);

        // Contention from reset: data, fetch, data, fetch, W+2 apart
        do_reset();
        fetchAddr = 16'h0040;
        dataAddr  = 16'h0300;
        dataRW    = 1'b1;
        fetchReq  = 1'b1;
        dataReq   = 1'b1;
        re_f  = 1'b0;
        re_d  = 1'b0;
        guard = 0;
        while (order.size() < 4 && guard < 60) begin
            step();
            guard++;
            if (re_f) fetchReq = 1'b1;
            if (re_d) dataReq = 1'b1;
            re_f = 1'b0;
            re_d = 1'b0;
            if (fetchAck) begin
                order.push_back(0);
                times.push_back(guard);
                fetchReq = 1'b0;
                re_f     = 1'b1;
            end
            if (dataAck) begin
                order.push_back(1);
                times.push_back(guard);
                dataReq = 1'b0;
                re_d    = 1'b1;
            end
        end
        if (order.size() < 4) begin
            n_total++;
            $display("FAIL tie_order: only %0d acks within 60 cycles", order.size());
        end else begin
            for (int i = 0; i < 4; i++) chk("tie_order", 32'(order[i]), 32'((i + 1) % 2));
            for (int i = 1; i < 4; i++) chk("tie_spacing", 32'(times[i] - times[i-1]), 32'(W + 2));
        end
        if (fetchReq) begin
            wait_ack(1'b0, "tie_drain_f", lat, ens);
            fetchReq = 1'b0;
        end
        if (dataReq) begin
            wait_ack(1'b1, "tie_drain_d", lat, ens);
            dataReq = 1'b0;
        end

        // Inputs changed and request dropped mid-access
        step();
        step();
        fetchAddr = 16'h0010;
        fetchReq  = 1'b1;
        step();
        fetchAddr = 16'h0020;
        fetchReq  = 1'b0;
        chk("latched_addr", 32'(memAddr), 32'h0010);
        wait_ack(1'b0, "dropped_req_ack", lat, ens);
        chk("dropped_req_latency", 32'(lat), 32'(W));
        chk("latched_addr_done", 32'(memAddr), 32'h0010);

        // Reset in second access cycle of a load
        step();
        dataRW   = 1'b1;
        dataAddr = 16'h0345;
        dataReq  = 1'b1;
        step();
        step();
        resetN = 1'b0;
        #1;
        chk("midrst_memEn", 32'(memEn), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_memAddr", 32'(memAddr), 32'd0);
        chk("midrst_memRW", 32'(memRW), 32'd0);
        chk("midrst_fetchData", fetchData, 32'd0);
        step();
        step();
        resetN = 1'b1;
        wait_ack(1'b1, "regrant_ack", lat, ens);
        dataReq = 1'b0;
        chk("regrant_latency", 32'(lat), 32'(W + 1));
        chk("regrant_rdata", dataRdata, rd_func(16'h0345));

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            step();
            if (fetchReq && fetchAck) begin
                fetchReq = 1'b0;
            end else if (!fetchReq && $urandom_range(0, 2) == 0) begin
                fetchAddr = ($urandom_range(0, 3) == 0) ? 16'h0010 : 16'($urandom);
                fetchReq  = 1'b1;
            end
            if (dataReq && dataAck) begin
                dataReq = 1'b0;
            end else if (!dataReq && $urandom_range(0, 2) == 0) begin
                dataRW    = 1'($urandom);
                dataAddr  = 16'($urandom);
                dataWdata = $urandom;
                dataReq   = 1'b1;
            end
        end
        guard = 0;
        while ((fetchReq || dataReq) && guard < 40) begin
            step();
            guard++;
            if (fetchAck) fetchReq = 1'b0;
            if (dataAck) dataReq = 1'b0;
        end
        if (fetchReq || dataReq) begin
            n_total++;
            $display("FAIL random_drain: requests still pending after 40 cycles");
        end
        step();
        step();
        step();
        chk("scoreboard_drained", 32'(ack_q.size()), 32'd0);

        aux_run(0, 1);
        aux_run(1, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
